fifo_drain_sched: RTL and testbench

- Round-robin drain scheduler for N_CH zero-latency FIFOs (delay-0, peek-style: data valid the same cycle as pop).
- Holds a grant on one channel for up to BURST pops, forwards each popped word into a single registered output stage with valid/ready handshake, then rotates.
- Sits between a bank of per-source FIFOs and a shared downstream consumer, e.g. a memory writer or a link serializer.

---
 rtl/fifo_sched_pkg.sv | 14 +
 rtl/fifo_drain_sched_rr_pick.sv | 28 ++
 rtl/fifo_drain_sched.sv | 149 ++++++++++++++
 tb/tb_fifo_drain_sched.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sched_pkg.sv
// Shared types and helpers for the FIFO drain scheduler.
package fifo_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_t;

    // Increment an index with wrap at n; n need not be a power of two.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_drain_sched_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above start, with wrap.
module rr_pick
    import fifo_sched_pkg::*;
#(
    parameter  int unsigned N_CH = 4,
    localparam int unsigned CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] start,
    output logic            found,
    output logic [CH_W-1:0] idx
);

    always_comb begin
        int unsigned pos;
        found = 1'b0;
        idx   = '0;
        pos   = 32'(start);
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (!found && req[CH_W'(pos)]) begin
                found = 1'b1;
                idx   = CH_W'(pos);
            end
            pos = next_idx(pos, N_CH);
        end
    end

endmodule

// File: rtl/fifo_drain_sched.sv
// Round-robin drain scheduler: bursts of up to BURST pops per grant from
// zero-latency FIFOs into one registered valid/ready output stage.
module fifo_drain_sched
    import fifo_sched_pkg::*;
#(
    parameter  int unsigned N_CH  = 4,
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned BURST = 4,
    localparam int unsigned CH_W  = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [N_CH-1:0]       ch_en,
    input  logic [N_CH-1:0]       fifo_valid,
    input  logic [N_CH*WIDTH-1:0] fifo_rdata,
    output logic [N_CH-1:0]       fifo_pop,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [CH_W-1:0]       out_ch,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int unsigned CNT_W = $clog2(BURST + 1);

    sched_state_t     state, state_next;
    logic [CH_W-1:0]  grant, grant_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CH_W-1:0]  rr, rr_next;
    logic             valid_next, last_next;
    logic [WIDTH-1:0] data_next, sel_data;
    logic [CH_W-1:0]  ch_next;

    logic [N_CH-1:0]  req;
    logic             load_ok, pop, at_end, req_g;
    logic             pick_found;
    logic [CH_W-1:0]  pick_start, pick_idx, after_g;

    // Data and request of the currently granted channel.
    always_comb begin
        sel_data = '0;
        req_g    = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (CH_W'(i) == grant) begin
                sel_data = fifo_rdata[i*WIDTH +: WIDTH];
                req_g    = req[i];
            end
        end
    end

    always_comb begin
        req        = fifo_valid & ch_en;
        load_ok    = !out_valid || out_ready;
        after_g    = CH_W'(next_idx(32'(grant), N_CH));
        pick_start = (state == GRANT) ? after_g : rr;
    end

    rr_pick #(.N_CH(N_CH)) u_pick (
        .req   (req),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Next-state, pop strobe and output-stage update.
    always_comb begin
        state_next = state;
        grant_next = grant;
        cnt_next   = cnt;
        rr_next    = rr;
        valid_next = out_valid;
        data_next  = out_data;
        ch_next    = out_ch;
        last_next  = out_last;
        fifo_pop   = '0;
        pop        = 1'b0;
        at_end     = (cnt == CNT_W'(BURST - 1));

        if (out_valid && out_ready) valid_next = 1'b0;

        if (flush) begin
            state_next = IDLE;
            cnt_next   = '0;
            valid_next = 1'b0;
            data_next  = '0;
            ch_next    = '0;
            last_next  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_next = pick_idx;
                        cnt_next   = '0;
                        state_next = GRANT;
                    end
                end
                GRANT: begin
                    pop = req_g && load_ok;
                    if (pop) begin
                        for (int unsigned i = 0; i < N_CH; i++)
                            fifo_pop[i] = (CH_W'(i) == grant);
                        data_next  = sel_data;
                        ch_next    = grant;
                        valid_next = 1'b1;
                        last_next  = at_end;
                        cnt_next   = cnt + CNT_W'(1);
                    end
                    // Release on burst end or dried/disabled channel; re-arbitrate with no bubble.
                    if ((pop && at_end) || (load_ok && !req_g)) begin
                        rr_next  = after_g;
                        cnt_next = '0;
                        if (pick_found) grant_next = pick_idx;
                        else            state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        if (!rst_n) fifo_pop = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            cnt       <= '0;
            rr        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_next;
            grant     <= grant_next;
            cnt       <= cnt_next;
            rr        <= rr_next;
            out_valid <= valid_next;
            out_data  <= data_next;
            out_ch    <= ch_next;
            out_last  <= last_next;
        end
    end

    assign busy = (state == GRANT) || out_valid;

endmodule

// File: tb/tb_fifo_drain_sched.sv
// Directed bench for fifo_drain_sched: behavioural FIFO bank, a per-cycle
// vector table for backpressure, and hand-written multi-cycle sequences.
module tb_fifo_drain_sched;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned BURST = 4;
    localparam int unsigned CH_W  = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  flush;
    logic [N_CH-1:0]       ch_en;
    logic [N_CH-1:0]       fifo_valid;
    logic [N_CH*WIDTH-1:0] fifo_rdata;
    logic [N_CH-1:0]       fifo_pop;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [CH_W-1:0]       out_ch;
    logic                  out_last;
    logic                  out_ready;
    logic                  busy;

    always #5 clk = ~clk;

    fifo_drain_sched #(.N_CH(N_CH), .WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .ch_en      (ch_en),
        .fifo_valid (fifo_valid),
        .fifo_rdata (fifo_rdata),
        .fifo_pop   (fifo_pop),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    function automatic logic [15:0] word(input int c, input int k);
        return 16'((c << 12) | k);
    endfunction

    // FIFO bank model: cnt words remaining, nxt index of head word.
    int              cnt [N_CH];
    int              nxt [N_CH];
    int              fill_cnt [N_CH];
    logic [N_CH-1:0] fill_mask;
    logic            fill_go = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (fill_go && fill_mask[i]) begin
                cnt[i] <= fill_cnt[i];
                nxt[i] <= 0;
            end else if (fifo_pop[i] && cnt[i] > 0) begin
                cnt[i] <= cnt[i] - 1;
                nxt[i] <= nxt[i] + 1;
            end
        end
    end

    always_comb begin
        fifo_valid = '0;
        fifo_rdata = '0;
        for (int i = 0; i < N_CH; i++) begin
            fifo_valid[i] = (cnt[i] > 0);
            fifo_rdata[i*WIDTH +: WIDTH] = word(i, nxt[i]);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Call at a negedge; new contents are visible from the next posedge.
    task automatic fill(input logic [3:0] m, input int c0, input int c1, input int c2, input int c3);
        fill_mask   = m;
        fill_cnt[0] = c0;
        fill_cnt[1] = c1;
        fill_cnt[2] = c2;
        fill_cnt[3] = c3;
        fill_go     = 1'b1;
        @(posedge clk);
        #1 fill_go = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        fill_mask = '1;
        for (int i = 0; i < N_CH; i++) fill_cnt[i] = 0;
        fill_go   = 1'b1;
        @(posedge clk);
        #1 fill_go = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [15:0] got_data [64];
    logic [1:0]  got_ch   [64];
    logic        got_last [64];
    int          got_cyc  [64];
    int          n_got;
    logic        pop1_seen;

    task automatic collect(input int n, input int budget);
        int cyc;
        cyc       = 0;
        n_got     = 0;
        pop1_seen = 1'b0;
        while (n_got < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (fifo_pop[1]) pop1_seen = 1'b1;
            if (out_valid && out_ready) begin
                got_data[n_got] = out_data;
                got_ch[n_got]   = out_ch;
                got_last[n_got] = out_last;
                got_cyc[n_got]  = cyc;
                n_got++;
            end
        end
        check("collect_count", 64'(n_got), 64'(n));
    endtask

    logic [15:0] exp_data [$];
    logic [1:0]  exp_ch   [$];
    logic        exp_last [$];

    task automatic add_burst(input int c, input int k0, input int len, input logic last_end);
        for (int j = 0; j < len; j++) begin
            exp_data.push_back(word(c, k0 + j));
            exp_ch.push_back(2'(c));
            exp_last.push_back(last_end && (j == len - 1));
        end
    endtask

    task automatic compare_words(input string tag);
        for (int i = 0; i < exp_data.size(); i++) begin
            if (i < n_got)
                check($sformatf("%s_w%0d", tag, i),
                      64'({got_ch[i], got_last[i], got_data[i]}),
                      64'({exp_ch[i], exp_last[i], exp_data[i]}));
        end
        exp_data.delete();
        exp_ch.delete();
        exp_last.delete();
    endtask

    typedef struct {
        logic             rdy;
        logic [N_CH-1:0]  pop;
        logic             vld;
        logic [WIDTH-1:0] data;
        logic [CH_W-1:0]  ch;
        logic             last;
        logic             busy;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [25:0] act, exp;

        // Channel 0 holds 6 words; ready drops for 3 cycles mid-burst, then once after the source dries.
        tbl[0]  = '{1'b1, 4'b0000, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 4'b0001, 1'b0, 16'h0, 2'd0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 4'b0001, 1'b1, 16'h0, 2'd0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 4'b0000, 1'b1, 16'h1, 2'd0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 4'b0000, 1'b1, 16'h1, 2'd0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 4'b0000, 1'b1, 16'h1, 2'd0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 4'b0001, 1'b1, 16'h1, 2'd0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 4'b0001, 1'b1, 16'h2, 2'd0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 4'b0001, 1'b1, 16'h3, 2'd0, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 4'b0001, 1'b1, 16'h4, 2'd0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 4'b0000, 1'b1, 16'h5, 2'd0, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 4'b0000, 1'b1, 16'h5, 2'd0, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 4'b0000, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0};

        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        ch_en     = '1;
        fill_mask = '1;
        for (int i = 0; i < N_CH; i++) fill_cnt[i] = 0;
        fill_go   = 1'b1;
        #1 check("reset_pop_comb", 64'(fifo_pop), 64'd0);
        repeat (2) @(posedge clk);
        #1 check("reset_state", 64'({out_valid, out_data, out_ch, out_last, busy, fifo_pop}), 64'd0);
        fill_go = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Backpressure vectors.
        do_reset();
        fill(4'b0001, 6, 0, 0, 0);
        for (int r = 0; r < 13; r++) begin
            @(negedge clk);
            out_ready = tbl[r].rdy;
            #1;
            act = {fifo_pop, out_valid, busy,
                   tbl[r].vld ? {out_ch, out_last, out_data} : 19'd0};
            exp = {tbl[r].pop, tbl[r].vld, tbl[r].busy,
                   tbl[r].vld ? {tbl[r].ch, tbl[r].last, tbl[r].data} : 19'd0};
            check($sformatf("bp_row%0d", r), 64'(act), 64'(exp));
        end
        out_ready = 1'b1;

        // Single channel, 10 words: bursts 4,4,2; last dried word carries no out_last.
        do_reset();
        fill(4'b0100, 0, 0, 10, 0);
        collect(10, 40);
        add_burst(2, 0, 4, 1'b1);
        add_burst(2, 4, 4, 1'b1);
        add_burst(2, 8, 2, 1'b0);
        compare_words("single");
        check("single_first_latency", 64'(got_cyc[0]), 64'd3);
        check("single_no_bubble", 64'(got_cyc[9] - got_cyc[0]), 64'd9);

        // All channels full: rotation 0,1,2,3,0.
        do_reset();
        fill(4'b1111, 8, 8, 8, 8);
        collect(20, 60);
        add_burst(0, 0, 4, 1'b1);
        add_burst(1, 0, 4, 1'b1);
        add_burst(2, 0, 4, 1'b1);
        add_burst(3, 0, 4, 1'b1);
        add_burst(0, 4, 4, 1'b1);
        compare_words("rr4");
        check("rr4_no_bubble", 64'(got_cyc[19] - got_cyc[0]), 64'd19);

        // Channel 1 disabled: order 0,2,3,0.
        do_reset();
        ch_en = 4'b1101;
        fill(4'b1111, 8, 8, 8, 8);
        collect(16, 60);
        add_burst(0, 0, 4, 1'b1);
        add_burst(2, 0, 4, 1'b1);
        add_burst(3, 0, 4, 1'b1);
        add_burst(0, 4, 4, 1'b1);
        compare_words("chen");
        check("chen_never_pop1", 64'(pop1_seen), 64'd0);
        check("chen_ch1_untouched", 64'(cnt[1]), 64'd8);
        ch_en = '1;

        // Flush mid-burst on channel 3 with pointer 0; channels 1 and 2 arrive with the flush.
        do_reset();
        fill(4'b1000, 0, 0, 0, 8);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("flush_pre", 64'({out_valid, out_ch, out_data}), 64'({1'b1, 2'd3, word(3, 1)}));
        flush       = 1'b1;
        fill_mask   = 4'b0110;
        fill_cnt[1] = 4;
        fill_cnt[2] = 4;
        fill_go     = 1'b1;
        #1 check("flush_pop", 64'(fifo_pop), 64'd0);
        @(posedge clk);
        #1;
        flush   = 1'b0;
        fill_go = 1'b0;
        check("flush_clear", 64'({out_valid, busy, out_last, out_data}), 64'd0);
        @(negedge clk);
        check("flush_idle_pop", 64'(fifo_pop), 64'd0);
        @(negedge clk);
        check("flush_regrant_pop", 64'(fifo_pop), 64'b0010);
        @(negedge clk);
        check("flush_regrant_out", 64'({out_valid, out_ch, out_data}), 64'({1'b1, 2'd1, word(1, 0)}));

        // Reset mid-grant after a release moved the pointer to 1.
        do_reset();
        fill(4'b0001, 8, 0, 0, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_pre", 64'({out_valid, busy}), 64'b11);
        rst_n       = 1'b0;
        fill_mask   = 4'b0010;
        fill_cnt[1] = 4;
        fill_go     = 1'b1;
        #1 check("rst_pop_comb", 64'(fifo_pop), 64'd0);
        @(posedge clk);
        #1;
        fill_go = 1'b0;
        rst_n   = 1'b1;
        check("rst_clear", 64'({out_valid, out_data, out_ch, out_last, busy}), 64'd0);
        @(negedge clk);
        check("rst_idle_pop", 64'(fifo_pop), 64'd0);
        collect(1, 10);
        check("rst_ptr_zero", 64'({got_ch[0], got_data[0]}), 64'({2'd0, word(0, 4)}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
